// File: rtl/l1_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l1_fill_ctrl
// Purpose  : L1 miss/fill and write-through controller between the CPU data
//            port, a two-way L1 data cache and backing memory. One outstanding
//            memory transaction; read misses fetch a whole line one word per
//            beat, stores are written through without allocation.
// Options  : CRITICAL_WORD_FIRST_EN - start the line fill at the missed word
//            and wrap around the line instead of starting at word 0.
// Revision : 1.0 - initial release
// ============================================================================
module l1_fill_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_SIZE  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_valid,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_w_data,
   input  logic                  cache_hit,
   output logic                  stall,
   output logic                  fill_en,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic                  fill_mark_valid,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_r_data
);

   localparam int c_BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int c_WORDS_PER_LINE = LINE_SIZE / c_BYTES_PER_WORD;
   localparam int c_WORD_BITS      = $clog2(c_BYTES_PER_WORD);
   localparam int c_OFF_BITS       = $clog2(LINE_SIZE);
   localparam int c_IDX_W          = c_OFF_BITS - c_WORD_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      WDONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [c_IDX_W-1:0]    r_beat;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic [c_IDX_W-1:0]    w_word_idx;
   logic [ADDR_WIDTH-1:0] w_line_base;
   logic [ADDR_WIDTH-1:0] w_beat_addr;
   logic                  w_miss;
   logic                  w_store;
   logic                  w_fill_ack;
   logic                  w_last_beat;

   assign w_miss      = cpu_valid & ~cpu_we & ~cache_hit;
   assign w_store     = cpu_valid & cpu_we;
   assign w_line_base = {cpu_addr[ADDR_WIDTH-1:c_OFF_BITS], {c_OFF_BITS{1'b0}}};

   // Acks only count while a fill request is actually outstanding.
   assign w_fill_ack  = (r_state == FILL) & mem_ack;
   assign w_last_beat = (r_beat == c_IDX_W'(c_WORDS_PER_LINE - 1));

`ifdef CRITICAL_WORD_FIRST_EN
   logic [c_IDX_W-1:0] r_start_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_idx <= '0;
      end else if ((r_state == IDLE) && w_miss) begin
         r_start_idx <= cpu_addr[c_OFF_BITS-1:c_WORD_BITS];
      end
   end

   // Beat counter stays 0-based so the 4th beat is still the one that marks valid.
   assign w_word_idx = r_beat + r_start_idx;
`else
   assign w_word_idx = r_beat;
`endif

   // r_addr holds the line base during FILL, so only the word offset is added.
   assign w_beat_addr = r_addr |
                        {{(ADDR_WIDTH-c_OFF_BITS){1'b0}}, w_word_idx, {c_WORD_BITS{1'b0}}};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE) begin
            if (w_miss) begin
               r_addr <= w_line_base;
               r_beat <= '0;
            end else if (w_store) begin
               r_addr  <= cpu_addr;
               r_wdata <= cpu_w_data;
            end
         end else if (w_fill_ack) begin
            r_beat <= r_beat + c_IDX_W'(1);
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_w_data   = '0;
      case (r_state)
         IDLE: begin
            stall = cpu_valid & (cpu_we | ~cache_hit);
            if (w_miss) begin
               w_next_state = FILL;
            end else if (w_store) begin
               w_next_state = WRITE;
            end
         end
         FILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = w_beat_addr;
            if (mem_ack && w_last_beat) begin
               w_next_state = IDLE;
            end
         end
         WRITE: begin
            stall      = 1'b1;
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = r_addr;
            mem_w_data = r_wdata;
            if (mem_ack) begin
               w_next_state = WDONE;
            end
         end
         // One unstalled cycle lets the store retire without being re-issued.
         WDONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign fill_en         = w_fill_ack;
   assign fill_addr       = w_fill_ack ? w_beat_addr : '0;
   assign fill_data       = w_fill_ack ? mem_r_data  : '0;
   assign fill_mark_valid = w_fill_ack & w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_l1_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_fill_ctrl
// Purpose  : Scoreboard bench for l1_fill_ctrl with a line-level L1 model and
//            a randomly delayed memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_fill_ctrl;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_valid = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_w_data = '0;
   logic        cache_hit;
   logic        stall;
   logic        fill_en;
   logic [31:0] fill_addr;
   logic [31:0] fill_data;
   logic        fill_mark_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_w_data;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_r_data = '0;

   logic        store_hit = 1'b0;
   bit [4095:0] l1_valid  = '0;
   bit [4095:0] mdl_valid = '0;

   exp_t exp_q[$];
   int   dly_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   l1_fill_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .cpu_valid       (cpu_valid),
      .cpu_we          (cpu_we),
      .cpu_addr        (cpu_addr),
      .cpu_w_data      (cpu_w_data),
      .cache_hit       (cache_hit),
      .stall           (stall),
      .fill_en         (fill_en),
      .fill_addr       (fill_addr),
      .fill_data       (fill_data),
      .fill_mark_valid (fill_mark_valid),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_w_data      (mem_w_data),
      .mem_ack         (mem_ack),
      .mem_r_data      (mem_r_data)
   );

   always #5 clk = ~clk;

   // L1 model: a line becomes visible only when the controller marks it valid.
   assign cache_hit = cpu_we ? store_hit : l1_valid[cpu_addr[15:4]];

   always @(posedge clk) begin
      if (fill_en && fill_mark_valid) l1_valid[fill_addr[15:4]] <= 1'b1;
   end

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Queue the four beats of a line fill; returns the cycles spent in FILL.
   function automatic int push_fill(input logic [31:0] addr, input int dlo, input int dhi);
      int   cycles;
      int   d;
      int   start;
      exp_t e;
      cycles = 0;
`ifdef CRITICAL_WORD_FIRST_EN
      start = int'(addr[3:2]);
`else
      start = 0;
`endif
      for (int b = 0; b < 4; b++) begin
         d = int'($urandom_range(dhi, dlo));
         dly_q.push_back(d);
         e.we   = 1'b0;
         e.addr = {addr[31:4], 4'h0} + 32'(((start + b) % 4) * 4);
         e.data = memdata(e.addr);
         e.last = (b == 3);
         exp_q.push_back(e);
         cycles += d + 1;
      end
      return cycles;
   endfunction

   task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input bit shit, input int dlo, input int dhi);
      int   exp_stall;
      int   cyc;
      int   d;
      exp_t e;
      exp_stall = 0;
      if (we) begin
         d = int'($urandom_range(dhi, dlo));
         dly_q.push_back(d);
         e.we   = 1'b1;
         e.addr = addr;
         e.data = data;
         e.last = 1'b0;
         exp_q.push_back(e);
         exp_stall = 1 + d + 1;
      end else if (!mdl_valid[addr[15:4]]) begin
         exp_stall = 1 + push_fill(addr, dlo, dhi);
         mdl_valid[addr[15:4]] = 1'b1;
      end
      @(posedge clk); #1;
      cpu_valid  = 1'b1;
      cpu_we     = we;
      cpu_addr   = addr;
      cpu_w_data = data;
      store_hit  = shit;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!stall) break;
         cyc++;
         if (cyc > 400) break;
      end
      check(we ? "store_stall_cycles" : "load_stall_cycles", 32'(cyc), 32'(exp_stall));
      @(posedge clk); #1;
      cpu_valid = 1'b0;
   endtask

   // Memory responder: each request waits its queued delay, then acks for one cycle.
   initial begin
      int wait_cnt;
      wait_cnt = -1;
      forever begin
         @(posedge clk); #1;
         mem_ack    = 1'b0;
         mem_r_data = $urandom;
         if (!mem_req) begin
            wait_cnt = -1;
         end else begin
            if (wait_cnt < 0) wait_cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            if (wait_cnt == 0) begin
               mem_ack    = 1'b1;
               mem_r_data = memdata(mem_addr);
               wait_cnt   = -1;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   // Monitor: every cycle a request is up it must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (mem_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else begin
               e = exp_q[0];
               check("mem_we", 32'(mem_we), 32'(e.we));
               check("mem_addr", mem_addr, e.addr);
               if (e.we) check("mem_w_data", mem_w_data, e.data);
               if (mem_ack) begin
                  void'(exp_q.pop_front());
                  check("fill_en", 32'(fill_en), 32'(!e.we));
                  if (!e.we) begin
                     check("fill_addr", fill_addr, e.addr);
                     check("fill_data", fill_data, e.data);
                     check("fill_mark_valid", 32'(fill_mark_valid), 32'(e.last));
                  end
               end else begin
                  check("fill_en_no_ack", 32'(fill_en), 32'd0);
               end
            end
         end else begin
            check("fill_en_idle", 32'(fill_en), 32'd0);
         end
      end
   end

   initial begin
      int unused_cycles;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_fill_en", 32'(fill_en), 32'd0);
      check("rst_fill_mark", 32'(fill_mark_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_txn(1'b0, 32'h0000_1008, '0, 1'b0, 0, 0);            // miss, ack every cycle
      do_txn(1'b0, 32'h0000_1008, '0, 1'b0, 0, 0);            // now a hit
      do_txn(1'b0, 32'h0000_1108, '0, 1'b0, 3, 3);            // miss, 3-cycle waits
      do_txn(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 0, 0); // store miss
      do_txn(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 2, 2); // store hit
      do_txn(1'b0, 32'h0000_1204, '0, 1'b0, 0, 1);            // miss then store back-to-back
      do_txn(1'b1, 32'h0000_1204, 32'h0BAD_F00D, 1'b1, 0, 1);

      // Reset in the middle of a fill: nothing must be marked valid.
      unused_cycles = push_fill(32'h0000_3004, 1, 1);
      @(posedge clk); #1;
      cpu_valid = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 32'h0000_3004;
      repeat (4) @(posedge clk);
      #1;
      cpu_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midfill_rst_mem_req", 32'(mem_req), 32'd0);
      check("midfill_rst_fill_en", 32'(fill_en), 32'd0);
      check("midfill_rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      dly_q.delete();
      do_txn(1'b0, 32'h0000_3004, '0, 1'b0, 0, 2);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = 32'h0000_1000 + 32'($urandom_range(31, 0) * 16) + 32'($urandom_range(3, 0) * 4);
         do_txn(1'($urandom_range(1, 0)), a, $urandom, 1'($urandom_range(1, 0)), 0, 3);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("final_mem_req", 32'(mem_req), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
